// File: rtl/multiplexed_seven_segments.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous buffering.
// Optional leading-zero blanking: define SEVSEG_LZ_BLANK_EN.
module multiplexed_seven_segments #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   inputNumber,
    input  logic [DIGITS-1:0]     dpIn,
    input  logic                  hexMode,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frameStart
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = hex ? 7'b1110111 : 7'b0000000;
            4'hB:    g = hex ? 7'b0011111 : 7'b0000000;
            4'hC:    g = hex ? 7'b1001110 : 7'b0000000;
            4'hD:    g = hex ? 7'b0111101 : 7'b0000000;
            4'hE:    g = hex ? 7'b1001111 : 7'b0000000;
            default: g = hex ? 7'b1000111 : 7'b0000000;
        endcase
        return g;
    endfunction

    logic [DW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_num_q, shadow_num_d;
    logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]   active_num_q, active_num_d;
    logic [DIGITS-1:0]     active_dp_q, active_dp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fs_q, fs_d;

    logic                  tick;
    logic                  commit;
    logic [IW-1:0]         next_idx;
    logic [DIGITS-1:0]     lz_mask;

    always_comb begin
        tick     = (div_q == DIV_LAST);
        next_idx = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        div_d    = tick ? '0 : div_q + DW'(1);
        idx_d    = tick ? next_idx : idx_q;

        shadow_num_d = load ? inputNumber : shadow_num_q;
        shadow_dp_d  = load ? dpIn : shadow_dp_q;

        // A load on the commit cycle lands in the shadow only and keeps pending set.
        commit       = tick && (next_idx == '0) && pending_q;
        active_num_d = commit ? shadow_num_q : active_num_q;
        active_dp_d  = commit ? shadow_dp_q : active_dp_q;
        pending_d    = load || (pending_q && !commit);
    end

`ifdef SEVSEG_LZ_BLANK_EN
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run && (active_num_d[4*k +: 4] == 4'h0);
            lz_mask[k] = (k > 0) && zero_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        logic [3:0]        nib;
        logic              nib_dp;
        logic              nib_lz;
        logic [DIGITS-1:0] an_sel;

        nib    = 4'h0;
        nib_dp = 1'b0;
        nib_lz = 1'b0;
        an_sel = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (next_idx == IW'(k)) begin
                nib       = active_num_d[4*k +: 4];
                nib_dp    = active_dp_d[k];
                nib_lz    = lz_mask[k];
                an_sel[k] = 1'b0;
            end
        end

        seg_d = seg_q;
        dp_d  = dp_q;
        an_d  = an_q;
        fs_d  = 1'b0;
        if (tick) begin
            seg_d = nib_lz ? 7'b1111111 : ~glyph(nib, hexMode);
            dp_d  = ~nib_dp;
            an_d  = an_sel;
            fs_d  = (next_idx == '0);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            div_q        <= '0;
            idx_q        <= '0;
            shadow_num_q <= '0;
            shadow_dp_q  <= '0;
            active_num_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            an_q         <= '1;
            fs_q         <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_num_q <= shadow_num_d;
            shadow_dp_q  <= shadow_dp_d;
            active_num_q <= active_num_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            fs_q         <= fs_d;
        end
    end

    assign segments   = seg_q;
    assign dp         = dp_q;
    assign anodes     = an_q;
    assign frameStart = fs_q;

endmodule

// File: doc/multiplexed_seven_segments.md
# multiplexed_seven_segments

Time-multiplexed driver for a bank of common-anode seven-segment digits, sitting in the Output stage after the processor's output register. It accepts a packed multi-digit nibble value through a load strobe and buffers it so frames never tear. It scans one digit at a time at a programmable rate and decodes each nibble in decimal or hexadecimal mode. It drives active-low segment, decimal-point and digit-enable lines.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; must be ≥ 2.
- `clock` in 1: single clock; all state changes on its rising edge.
- `resetN` in 1: reset, asynchronous assert, active-low.
- `load` in 1: when high, `inputNumber` and `dpIn` are captured into the shadow buffer.
- `inputNumber` in 4*DIGITS: packed nibbles; bits [3:0] are digit 0 (rightmost), bits [4k+3:4k] are digit k.
- `dpIn` in DIGITS: decimal point request per digit, active-high, bit k belongs to digit k.
- `hexMode` in 1: 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = nibbles 10..15 are blank.
- `segments` out 7: {A,B,C,D,E,F,G}, active-low, registered.
- `dp` out 1: decimal point, active-low, registered.
- `anodes` out DIGITS: digit enables, active-low one-hot, registered; bit k enables digit k.
- `frameStart` out 1: one-cycle high pulse on the cycle digit 0 becomes enabled.

## Operation
- Prescaler `div` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when `div == SCAN_DIV-1`.
- Digit index `idx` ranges 0..DIGITS-1. On `tick`: `next = (idx == DIGITS-1) ? 0 : idx+1`, and `idx <= next`.
- Two buffers are kept:
  - Shadow: the value plus dp, written on any cycle with `load` high; the last write wins.
  - Active: what is actually displayed.
- A `pending` flag is set by `load`. On a `tick` with `next == 0` and `pending` set, active <= shadow and `pending` clears.
- `load` on that same cycle: its data goes to the shadow only and `pending` stays set, so it is shown next frame.
- On every `tick`, all registered outputs update together from `next` and the post-update active buffer:
  - `anodes` <= all ones except bit `next` = 0.
  - `segments` <= ~glyph(active nibble `next`).
  - `dp` <= ~active dp bit `next`.
  - `frameStart` <= (`next == 0`).
- Between ticks all outputs hold, except `frameStart`, which returns to 0.
- Glyph table (A..G, active-high):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - hex: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - blank=0000000
- `hexMode` is sampled combinationally at each tick. It is not buffered.
- DIGITS=1: `idx` stays 0, every tick is a frame start, and `anodes` is constantly 0 after the first tick.

## Timing
- Reset values: `segments`=7'b1111111, `dp`=1, `anodes`=all ones, `frameStart`=0. `div`, `idx`, both buffers and `pending` are all 0.
- The first tick after reset release (cycle SCAN_DIV-1) enables digit 1 (or digit 0 if DIGITS=1). The first `frameStart` follows DIGITS ticks later.
- Latency from `load` to visible change: until the next frame boundary, at most DIGITS*SCAN_DIV cycles.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronously) and any pending load is discarded.

## Configuration
- `SEVSEG_LZ_BLANK_EN` defined: leading-zero blanking is enabled.
  - Digit k > 0 is blanked (segments all 1) when nibbles k..DIGITS-1 of the active buffer are all zero.
  - Digit 0 is never blanked.
  - The dp of a blanked digit is still driven from `dpIn`.
- Not defined: every digit shows its glyph, including leading zeros.

## Test plan
- Reset: hold `resetN`=0 then release → `segments`=1111111, `anodes`=1111, `dp`=1 until the first tick at cycle SCAN_DIV-1.
- Scan (DIGITS=4, SCAN_DIV=4), load 16'h1234 → after the frame boundary, digits 0..3 show segments ~0110011, ~1111001, ~1101101, ~0110000 with `anodes` 1110, 1101, 1011, 0111. `frameStart` pulses every 16 cycles.
- Hex mode, load 16'hABCD:
  - `hexMode`=1 → digit 0 segments = ~0111101.
  - `hexMode`=0 → all four digits blank (1111111).
- Tearing: load 16'h1111, then load 16'h2222 while digit 2 is enabled → digits 2,3 still show 1 for the rest of that frame; all digits show 2 from the next `frameStart`.
- Leading-zero blanking (macro defined), load 16'h0050 → digits 3 and 2 blank, digit 1 = ~1011011, digit 0 = ~1111110. Without the macro, digits 3 and 2 = ~1111110.
- Mid-scan reset: assert `resetN`=0 with `load` pending → outputs go to reset values in the same cycle; after release the display shows 0, not the pending value.
